// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble, one shift-and-correct step per clock.
// Start/done handshake with an error flag for invalid digits and for results that do not fit OUTPUT_WIDTH.
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 2,
  parameter int OUTPUT_WIDTH   = 7
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_Start,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  output logic [OUTPUT_WIDTH-1:0]       o_Binary,
  output logic                          o_DV,
  output logic                          o_Busy,
  output logic                          o_Error
);

  localparam int BCD_W = DECIMAL_DIGITS * 4;
  localparam int CAT_W = BCD_W + OUTPUT_WIDTH;
  localparam int CNT_W = $clog2(OUTPUT_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OUTPUT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_CONVERT = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [BCD_W-1:0]        r_bcd;
  logic [OUTPUT_WIDTH-1:0] r_bin;
  logic [CNT_W-1:0]        r_count;
  logic [OUTPUT_WIDTH-1:0] r_binary;
  logic                    r_dv;
  logic                    r_busy;
  logic                    r_error;

  logic [CAT_W-1:0]        w_shift;
  logic [BCD_W-1:0]        w_bcd_next;
  logic [OUTPUT_WIDTH-1:0] w_bin_next;
  logic                    w_digit_bad;
  logic                    w_last;
  logic                    w_overflow;

  // One reverse double-dabble step: shift right, then pull back any digit that crossed 8.
  assign w_shift    = {r_bcd, r_bin} >> 1;
  assign w_bin_next = w_shift[OUTPUT_WIDTH-1:0];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_bcd_next = w_shift[CAT_W-1:OUTPUT_WIDTH];
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (w_bcd_next[d*4 +: 4] >= 4'd8) begin
        w_bcd_next[d*4 +: 4] = w_bcd_next[d*4 +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_digit_bad = 1'b0;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (i_BCD[d*4 +: 4] > 4'd9) begin
        w_digit_bad = 1'b1;
      end
    end
  end

  assign w_last     = (r_count == LAST_STEP);
  assign w_overflow = (w_bcd_next != '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (i_Start && !w_digit_bad) w_state_next = S_CONVERT;
      S_CONVERT: if (w_last)                  w_state_next = S_IDLE;
      default:                                w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: all datapath state is plain flops, so everything is cleared by reset; a reset abandons any conversion.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_bcd    <= '0;
      r_bin    <= '0;
      r_count  <= '0;
      r_binary <= '0;
      r_dv     <= 1'b0;
      r_busy   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_Start) begin
            r_bcd   <= i_BCD;
            r_bin   <= '0;
            r_count <= '0;
            r_error <= 1'b0;
            if (w_digit_bad) begin
              r_binary <= '0;
              r_error  <= 1'b1;
              r_dv     <= 1'b1;
            end else begin
              r_busy <= 1'b1;
            end
          end
        end
        S_CONVERT: begin
          r_bcd   <= w_bcd_next;
          r_bin   <= w_bin_next;
          r_count <= r_count + CNT_ONE;
          if (w_last) begin
            r_busy <= 1'b0;
            r_dv   <= 1'b1;
            // Leftover decimal weight means the value needs more than OUTPUT_WIDTH bits.
            if (w_overflow) begin
              r_error  <= 1'b1;
              r_binary <= '0;
            end else begin
              r_binary <= w_bin_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Binary = r_binary;
  assign o_DV     = r_dv;
  assign o_Busy   = r_busy;
  assign o_Error  = r_error;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: a default instance (7-bit) and a 6-bit instance for overflow.
// Drivers push expected result and expected o_DV cycle; monitors pop on every o_DV and also track o_Busy.
module tb_bcd_to_binary;

  typedef struct {
    int bin;
    int err;
    int cyc;
  } exp_t;

  localparam int MODE_VALID   = 0;
  localparam int MODE_ERROR   = 1;
  localparam int MODE_IGNORED = 2;

  logic       clk;
  logic       rst_n;
  logic       start7, start6;
  logic [7:0] bcd7, bcd6;
  logic [6:0] bin7;
  logic [5:0] bin6;
  logic       dv7, busy7, err7;
  logic       dv6, busy6, err6;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q7[$];
  exp_t q6[$];
  int   b7_lo = 1, b7_hi = 0;
  int   b6_lo = 1, b6_hi = 0;

  bcd_to_binary u_dut7 (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .i_Start (start7),
    .i_BCD   (bcd7),
    .o_Binary(bin7),
    .o_DV    (dv7),
    .o_Busy  (busy7),
    .o_Error (err7)
  );

  bcd_to_binary #(.DECIMAL_DIGITS(2), .OUTPUT_WIDTH(6)) u_dut6 (
    .i_Clock (clk),
    .i_Rst_L (rst_n),
    .i_Start (start6),
    .i_BCD   (bcd6),
    .o_Binary(bin6),
    .o_DV    (dv6),
    .o_Busy  (busy6),
    .o_Error (err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Drives one i_Start pulse; expected o_DV lands OUTPUT_WIDTH+1 cycles after the drive cycle, or 1 for a bad digit.
  task automatic issue(input int dut, input logic [7:0] bcd, input int exp_bin, input int mode);
    exp_t e;
    int   steps;
    @(negedge clk);
    steps = (dut == 7) ? 7 : 6;
    if (dut == 7) begin start7 = 1'b1; bcd7 = bcd; end
    else          begin start6 = 1'b1; bcd6 = bcd; end
    e.bin = exp_bin;
    e.err = (mode == MODE_ERROR || exp_bin < 0) ? 1 : 0;
    if (e.err != 0) e.bin = 0;
    if (mode == MODE_ERROR) e.cyc = cyc + 1;
    else                    e.cyc = cyc + steps + 1;
    if (mode != MODE_IGNORED) begin
      if (dut == 7) q7.push_back(e); else q6.push_back(e);
    end
    if (mode == MODE_VALID) begin
      if (dut == 7) begin b7_lo = cyc + 1; b7_hi = cyc + steps; end
      else          begin b6_lo = cyc + 1; b6_hi = cyc + steps; end
    end
    @(negedge clk);
    if (dut == 7) begin start7 = 1'b0; bcd7 = 8'h00; end
    else          begin start6 = 1'b0; bcd6 = 8'h00; end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("busy7", {31'd0, busy7}, (cyc >= b7_lo && cyc <= b7_hi) ? 1 : 0);
      if (dv7) begin
        if (q7.size() == 0) begin
          check("dv7_unexpected", 1, 0);
        end else begin
          e = q7.pop_front();
          check("bin7", {25'd0, bin7}, e.bin);
          check("err7", {31'd0, err7}, e.err);
          check("dv7_cycle", cyc, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      check("busy6", {31'd0, busy6}, (cyc >= b6_lo && cyc <= b6_hi) ? 1 : 0);
      if (dv6) begin
        if (q6.size() == 0) begin
          check("dv6_unexpected", 1, 0);
        end else begin
          e = q6.pop_front();
          check("bin6", {26'd0, bin6}, e.bin);
          check("err6", {31'd0, err6}, e.err);
          check("dv6_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start7 = 1'b0; bcd7 = 8'h00;
    start6 = 1'b0; bcd6 = 8'h00;
    #1;
    check("rst_bin7",  {25'd0, bin7},  0);
    check("rst_dv7",   {31'd0, dv7},   0);
    check("rst_busy7", {31'd0, busy7}, 0);
    check("rst_err7",  {31'd0, err7},  0);
    check("rst_bin6",  {26'd0, bin6},  0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Single conversion, then the result must hold while idle.
    issue(7, 8'h10, 10, MODE_VALID);
    repeat (12) @(negedge clk);
    check("hold_bin7", {25'd0, bin7}, 10);
    check("hold_err7", {31'd0, err7}, 0);

    // Back-to-back, each start issued in the previous o_DV cycle.
    issue(7, 8'h00, 0, MODE_VALID);
    repeat (6) @(negedge clk);
    issue(7, 8'h11, 11, MODE_VALID);
    repeat (6) @(negedge clk);
    issue(7, 8'h99, 99, MODE_VALID);
    repeat (10) @(negedge clk);

    // Invalid digits: one-cycle error response, never busy, error held afterwards.
    issue(7, 8'h1A, 0, MODE_ERROR);
    issue(7, 8'hF0, 0, MODE_ERROR);
    repeat (4) @(negedge clk);
    check("held_err7", {31'd0, err7}, 1);
    check("held_bin7", {25'd0, bin7}, 0);

    // Overflow at the 6-bit boundary, then the largest value that fits.
    issue(6, 8'h64, -1, MODE_VALID);
    repeat (8) @(negedge clk);
    issue(6, 8'h63, 63, MODE_VALID);
    repeat (8) @(negedge clk);

    // Start while busy is ignored; the in-flight 42 completes alone.
    issue(7, 8'h42, 42, MODE_VALID);
    @(negedge clk);
    issue(7, 8'h07, 0, MODE_IGNORED);
    repeat (10) @(negedge clk);

    // Reset during CONVERT aborts with no o_DV, then a fresh conversion works.
    issue(7, 8'h55, 55, MODE_VALID);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    q7.delete();
    b7_lo = 1; b7_hi = 0;
    #1;
    check("midrst_bin7",  {25'd0, bin7},  0);
    check("midrst_dv7",   {31'd0, dv7},   0);
    check("midrst_busy7", {31'd0, busy7}, 0);
    check("midrst_err7",  {31'd0, err7},  0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(7, 8'h55, 55, MODE_VALID);
    repeat (12) @(negedge clk);

    check("pending7", q7.size(), 0);
    check("pending6", q6.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
